decode_pipe: RTL and testbench

Parametrised, registered successor to the combinational decode stage. It accepts one 16-bit instruction per cycle from fetch over a valid/ready handshake, decodes it into the control bundle, and holds the result in an ID/EX output register. It also performs load-use stall detection, branch flush, and halt latching. It sits between fetch and execute and provides the stall and bubble source for the pipeline.

---
 rtl/decode_pipe.sv | 196 +++++++++++++++++++
 tb/tb_decode_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Registered decode stage: decodes one 16-bit instruction per cycle into an ID/EX
// control bundle, with load-use stall detection, branch flush and sticky halt.
module decode_pipe #(
    parameter int DATA_W    = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc2,
    output logic              in_ready,
    input  logic              out_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [3:0]        out_rd,
    output logic [3:0]        out_rs,
    output logic [3:0]        out_rt,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc2,
    output logic [3:0]        out_alu_op,
    output logic              out_alu_src1,
    output logic              out_alu_src2,
    output logic              out_mem_we,
    output logic              out_mem_re,
    output logic              out_reg_we,
    output logic              out_reg_wsrc,
    output logic              out_branch,
    output logic [2:0]        out_branch_cond,
    output logic              out_halt,
    output logic              halted
);

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
        OP_SLL    = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
        OP_LW     = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
        OP_B      = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    typedef struct packed {
        logic [3:0]        rd;
        logic [3:0]        rs;
        logic [3:0]        rt;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc2;
        logic [3:0]        alu_op;
        logic              alu_src1;
        logic              alu_src2;
        logic              mem_we;
        logic              mem_re;
        logic              reg_we;
        logic              reg_wsrc;
        logic              branch;
        logic [2:0]        cond;
        logic              halt;
    } bundle_t;

    opcode_t w_op;
    bundle_t w_dec;
    logic    w_reads_rs;
    logic    w_reads_rt;
    logic    w_hazard;
    logic    w_accept;

    bundle_t r_out;
    logic    r_valid;
    logic    r_halted;

    always_comb begin
        w_op        = opcode_t'(in_instr[15:12]);
        w_dec       = '0;
        w_dec.rd    = in_instr[11:8];
        w_dec.rs    = in_instr[7:4];
        w_dec.rt    = in_instr[3:0];
        w_dec.imm   = {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
        w_dec.pc2   = in_pc2;
        w_reads_rs  = 1'b0;
        w_reads_rt  = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                case (w_op)
                    OP_SUB:    w_dec.alu_op = 4'd1;
                    OP_XOR:    w_dec.alu_op = 4'd2;
                    OP_RED:    w_dec.alu_op = 4'd8;
                    OP_PADDSB: w_dec.alu_op = 4'd9;
                    default:   w_dec.alu_op = 4'd0;
                endcase
                w_dec.reg_we = 1'b1;
                w_reads_rs   = 1'b1;
                w_reads_rt   = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                w_dec.alu_op   = {2'b01, w_op[1:0]};
                w_dec.alu_src2 = 1'b1;
                w_dec.reg_we   = 1'b1;
                w_reads_rs     = 1'b1;
            end
            OP_LW: begin
                w_dec.alu_op   = 4'd10;
                w_dec.alu_src2 = 1'b1;
                w_dec.imm      = {{(DATA_W-5){in_instr[3]}}, in_instr[3:0], 1'b0};
                w_dec.reg_we   = 1'b1;
                w_dec.reg_wsrc = 1'b1;
                w_dec.mem_re   = 1'b1;
                w_reads_rs     = 1'b1;
            end
            OP_SW: begin
                // store data register lives in the rd slot of the encoding
                w_dec.rt       = in_instr[11:8];
                w_dec.alu_op   = 4'd10;
                w_dec.alu_src2 = 1'b1;
                w_dec.imm      = {{(DATA_W-5){in_instr[3]}}, in_instr[3:0], 1'b0};
                w_dec.mem_we   = 1'b1;
                w_reads_rs     = 1'b1;
                w_reads_rt     = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                w_dec.rs       = in_instr[11:8];
                w_dec.alu_op   = w_op[0] ? 4'd12 : 4'd11;
                w_dec.alu_src2 = 1'b1;
                w_dec.imm      = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
                w_dec.reg_we   = 1'b1;
                w_reads_rs     = 1'b1;
            end
            OP_B: begin
                w_dec.alu_op   = 4'd10;
                w_dec.alu_src1 = 1'b1;
                w_dec.alu_src2 = 1'b1;
                w_dec.imm      = {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};
                w_dec.branch   = 1'b1;
                w_dec.cond     = in_instr[11:9];
            end
            OP_BR: begin
                w_dec.alu_op = 4'd13;
                w_dec.branch = 1'b1;
                w_dec.cond   = in_instr[11:9];
                w_reads_rs   = 1'b1;
            end
            OP_PCS: begin
                w_dec.alu_op   = 4'd13;
                w_dec.alu_src1 = 1'b1;
                w_dec.reg_we   = 1'b1;
            end
            OP_HLT: begin
                w_dec.halt = 1'b1;
            end
        endcase
    end

    // A load still in the output register cannot forward; hold back any reader of its rd.
    assign w_hazard = HAZARD_EN && r_valid && r_out.mem_re && (r_out.rd != 4'd0) &&
                      ((w_reads_rs && (w_dec.rs == r_out.rd)) ||
                       (w_reads_rt && (w_dec.rt == r_out.rd)));

    assign in_ready = !rst && !flush && !r_halted && !w_hazard && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_accept) begin
            r_out   <= w_dec;
            r_valid <= 1'b1;
            if (w_dec.halt) begin
                r_halted <= 1'b1;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid       = r_valid;
    assign halted          = r_halted;
    assign out_rd          = r_out.rd;
    assign out_rs          = r_out.rs;
    assign out_rt          = r_out.rt;
    assign out_imm         = r_out.imm;
    assign out_pc2         = r_out.pc2;
    assign out_alu_op      = r_out.alu_op;
    assign out_alu_src1    = r_out.alu_src1;
    assign out_alu_src2    = r_out.alu_src2;
    assign out_mem_we      = r_out.mem_we;
    assign out_mem_re      = r_out.mem_re;
    assign out_reg_we      = r_out.reg_we;
    assign out_reg_wsrc    = r_out.reg_wsrc;
    assign out_branch      = r_out.branch;
    assign out_branch_cond = r_out.cond;
    assign out_halt        = r_out.halt;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: hand-derived expected bundles are queued on
// acceptance and compared when execute consumes the output register.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc2;
    logic        out_ready;
    logic        flush;

    logic        in_ready, out_valid, halted;
    logic [3:0]  out_rd, out_rs, out_rt, out_alu_op;
    logic [15:0] out_imm, out_pc2;
    logic        out_alu_src1, out_alu_src2, out_mem_we, out_mem_re;
    logic        out_reg_we, out_reg_wsrc, out_branch, out_halt;
    logic [2:0]  out_branch_cond;

    logic        nh_in_ready, nh_out_valid, nh_halted;
    logic [3:0]  nh_rd, nh_rs, nh_rt, nh_alu_op;
    logic [15:0] nh_imm, nh_pc2;
    logic        nh_src1, nh_src2, nh_mem_we, nh_mem_re;
    logic        nh_reg_we, nh_reg_wsrc, nh_branch, nh_halt;
    logic [2:0]  nh_cond;

    decode_pipe #(.DATA_W(16), .HAZARD_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc2(in_pc2),
        .in_ready(in_ready), .out_ready(out_ready), .flush(flush), .out_valid(out_valid),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_pc2(out_pc2), .out_alu_op(out_alu_op), .out_alu_src1(out_alu_src1),
        .out_alu_src2(out_alu_src2), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
        .out_reg_we(out_reg_we), .out_reg_wsrc(out_reg_wsrc), .out_branch(out_branch),
        .out_branch_cond(out_branch_cond), .out_halt(out_halt), .halted(halted)
    );

    decode_pipe #(.DATA_W(16), .HAZARD_EN(1'b0)) u_dut_nh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc2(in_pc2),
        .in_ready(nh_in_ready), .out_ready(out_ready), .flush(flush), .out_valid(nh_out_valid),
        .out_rd(nh_rd), .out_rs(nh_rs), .out_rt(nh_rt), .out_imm(nh_imm),
        .out_pc2(nh_pc2), .out_alu_op(nh_alu_op), .out_alu_src1(nh_src1),
        .out_alu_src2(nh_src2), .out_mem_we(nh_mem_we), .out_mem_re(nh_mem_re),
        .out_reg_we(nh_reg_we), .out_reg_wsrc(nh_reg_wsrc), .out_branch(nh_branch),
        .out_branch_cond(nh_cond), .out_halt(nh_halt), .halted(nh_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] regs;
        logic [15:0] imm;
        logic [15:0] pc2;
        logic [3:0]  alu;
        logic [7:0]  fl;
        logic [2:0]  cond;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   exp_lat = 1;
    logic nh_first, ov_last, nh_ov_last;

    logic [7:0]  flags;
    logic [58:0] fields;
    assign flags  = {out_alu_src1, out_alu_src2, out_mem_we, out_mem_re,
                     out_reg_we, out_reg_wsrc, out_branch, out_halt};
    assign fields = {out_rd, out_rs, out_rt, out_imm, out_pc2, out_alu_op, flags, out_branch_cond};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // flags order: {src1, src2, mem_we, mem_re, reg_we, wsrc, branch, halt}
    function automatic exp_t E(input logic [11:0] regs, input logic [15:0] imm,
                               input logic [3:0] alu, input logic [7:0] fl, input logic [2:0] cond);
        exp_t e;
        e.regs = regs; e.imm = imm; e.alu = alu; e.fl = fl; e.cond = cond;
        e.pc2 = '0; e.acc = 0; e.lat = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_underflow", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("regs",    {out_rd, out_rs, out_rt}, e.regs);
                check("imm",     out_imm, e.imm);
                check("pc2",     out_pc2, e.pc2);
                check("alu_op",  out_alu_op, e.alu);
                check("flags",   flags, e.fl);
                check("cond",    out_branch_cond, e.cond);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic send(input logic [15:0] instr, input logic [15:0] pc2, input exp_t e,
                        output int stalls);
        in_valid = 1'b1; in_instr = instr; in_pc2 = pc2; stalls = 0;
        @(negedge clk);
        nh_first = nh_in_ready;
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        ov_last    = out_valid;
        nh_ov_last = nh_out_valid;
        if (!in_ready) begin
            check("accept_timeout", stalls, 0);
        end else begin
            e.pc2 = pc2; e.acc = cyc; e.lat = exp_lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        q.delete();
        @(posedge clk); @(negedge clk);
        check("rst_ctl",    {out_valid, halted, in_ready}, 3'b000);
        check("rst_fields", fields, 59'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst", {out_valid, halted, in_ready}, 3'b001);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int tot;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc2 = '0;
        out_ready = 1'b1; flush = 1'b0;
        do_reset();

        // basic stream, full throughput
        send(16'h1123, 16'h0002, E(12'h123, 16'h0003, 4'd1,  8'b0000_1000, 3'd0), st);
        check("sub_stall", st, 0);
        send(16'h8452, 16'h0004, E(12'h452, 16'h0004, 4'd10, 8'b0101_1100, 3'd0), st);
        check("lw_stall", st, 0);

        // load-use: ADD reads R3 loaded by the LW in the output register
        send(16'h8312, 16'h0006, E(12'h312, 16'h0004, 4'd10, 8'b0101_1100, 3'd0), st);
        check("lw2_stall", st, 0);
        send(16'h0435, 16'h0008, E(12'h435, 16'h0005, 4'd0,  8'b0000_1000, 3'd0), st);
        check("lu_stall",    st, 1);
        check("lu_bubble",   ov_last, 0);
        check("nh_ready",    nh_first, 1);
        check("nh_nobubble", nh_ov_last, 1);

        // load to R0 never stalls
        send(16'h8012, 16'h000A, E(12'h012, 16'h0004, 4'd10, 8'b0101_1100, 3'd0), st);
        send(16'h0105, 16'h000C, E(12'h105, 16'h0005, 4'd0,  8'b0000_1000, 3'd0), st);
        check("r0_stall", st, 0);

        // branch then flush with a new instruction presented
        send(16'hC1FF, 16'h000E, E(12'h1FF, 16'hFFFE, 4'd10, 8'b1100_0010, 3'd0), st);
        in_valid = 1'b1; in_instr = 16'h0123; flush = 1'b1;
        @(negedge clk);
        check("flush_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_squash", out_valid, 0);
        @(posedge clk); #1;

        // remaining opcodes, including SW reading its data register from [11:8]
        tot = 0;
        send(16'hD5A0, 16'h0010, E(12'h5A0, 16'h0000, 4'd13, 8'b0000_0010, 3'd2), st); tot += st;
        send(16'hE700, 16'h0012, E(12'h700, 16'h0000, 4'd13, 8'b1000_1000, 3'd0), st); tot += st;
        send(16'h5123, 16'h0014, E(12'h123, 16'h0003, 4'd5,  8'b0100_1000, 3'd0), st); tot += st;
        send(16'h8A12, 16'h0016, E(12'hA12, 16'h0004, 4'd10, 8'b0101_1100, 3'd0), st); tot += st;
        send(16'h9A34, 16'h0018, E(12'hA3A, 16'h0008, 4'd10, 8'b0110_0000, 3'd0), st);
        check("sw_rt_stall", st, 1);
        send(16'h8E2F, 16'h001A, E(12'hE2F, 16'hFFFE, 4'd10, 8'b0101_1100, 3'd0), st); tot += st;
        send(16'h3456, 16'h001C, E(12'h456, 16'h0006, 4'd8,  8'b0000_1000, 3'd0), st); tot += st;
        send(16'h7ABC, 16'h001E, E(12'hABC, 16'hFFFC, 4'd9,  8'b0000_1000, 3'd0), st); tot += st;
        send(16'h2F0F, 16'h0020, E(12'hF0F, 16'hFFFF, 4'd2,  8'b0000_1000, 3'd0), st); tot += st;
        check("stream_stalls", tot, 0);

        // backpressure: LLB held three cycles
        exp_lat = 4;
        send(16'hA1AB, 16'h0030, E(12'h11B, 16'h00AB, 4'd11, 8'b0100_1000, 3'd0), st);
        exp_lat = 1;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hB2CD; in_pc2 = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_imm",   out_imm, 16'h00AB);
            check("bp_rs",    out_rs, 4'h1);
            check("bp_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'hB2CD, 16'h0040, E(12'h22D, 16'h00CD, 4'd12, 8'b0100_1000, 3'd0), st);
        check("bp_release_stall", st, 0);

        // halt latches until flush
        send(16'hF000, 16'h0050, E(12'h000, 16'h0000, 4'd0, 8'b0000_0001, 3'd0), st);
        in_valid = 1'b1; in_instr = 16'h0123;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("halt_hold", {halted, in_ready}, 2'b10);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("halt_flush", {halted, in_ready}, 2'b01);
        @(posedge clk); #1;
        send(16'h0123, 16'h0052, E(12'h123, 16'h0003, 4'd0, 8'b0000_1000, 3'd0), st);
        check("post_halt_stall", st, 0);

        // reset while a bundle is held under backpressure
        out_ready = 1'b0;
        @(negedge clk);
        check("hold_before_rst", out_valid, 1);
        do_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
